// File: rtl/gray_bin_conv_pipe.sv
// Pipelined Gray<->binary converter with valid/ready flow control and a sideband tag.
// Gray->binary runs a Sklansky prefix-XOR over the bit-reversed word, split across STAGES registers.
module gray_bin_conv_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_mode_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [TAG_W-1:0] out_tag_o
);

    localparam int M = $clog2(WIDTH);

    // Handshake: a stage advances when it is empty or the stage after it advances;
    // the last stage's successor is the consumer (out_ready_i). Words move only on advance.

    function automatic logic [WIDTH-1:0] f_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // Apply Sklansky levels [lo, hi): bit j with bit l set absorbs the top of its lower half-block.
    function automatic logic [WIDTH-1:0] f_levels(input logic [WIDTH-1:0] v, input int lo, input int hi);
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] nxt;
        cur = v;
        for (int l = 0; l < M; l++) begin
            nxt = cur;
            if (l >= lo && l < hi) begin
                for (int j = 0; j < WIDTH; j++) begin
                    if (((j >> l) & 1) == 1) begin
                        nxt[j] = cur[j] ^ cur[((j >> l) << l) - 1];
                    end
                end
            end
            cur = nxt;
        end
        return cur;
    endfunction

    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_mode;
    logic [STAGES-1:0] w_adv;
    logic [WIDTH-1:0]  w_data [STAGES];
    logic [TAG_W-1:0]  w_tag  [STAGES];
    logic [WIDTH-1:0]  w_in_gray;

    assign w_in_gray = in_data_i ^ (in_data_i >> 1);

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = s * M / STAGES;
        localparam int HI = (s + 1) * M / STAGES;

        logic             r_valid;
        logic [WIDTH-1:0] r_data;
        logic [TAG_W-1:0] r_tag;
        logic             r_mode;
        logic             w_nvalid;
        logic [WIDTH-1:0] w_ndata;
        logic [TAG_W-1:0] w_ntag;
        logic             w_nmode;

        // Binary->Gray words are finished in stage 1 and kept un-reversed from then on.
        if (s == 0) begin : g_first
            assign w_nvalid = in_valid_i;
            assign w_nmode  = in_mode_i;
            assign w_ntag   = in_tag_i;
            assign w_ndata  = in_mode_i ? w_in_gray : f_levels(f_rev(in_data_i), LO, HI);
        end else begin : g_next
            assign w_nvalid = w_valid[s-1];
            assign w_nmode  = w_mode[s-1];
            assign w_ntag   = w_tag[s-1];
            assign w_ndata  = w_mode[s-1] ? w_data[s-1] : f_levels(w_data[s-1], LO, HI);
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_tag   <= '0;
                r_mode  <= 1'b0;
            end else if (w_adv[s]) begin
                r_valid <= w_nvalid;
                r_data  <= w_ndata;
                r_tag   <= w_ntag;
                r_mode  <= w_nmode;
            end
        end

        assign w_valid[s] = r_valid;
        assign w_mode[s]  = r_mode;
        assign w_data[s]  = r_data;
        assign w_tag[s]   = r_tag;
        // Unrolled ready chain: advance if the consumer is ready or any stage from here on is empty.
        assign w_adv[s]   = out_ready_i | ~(&w_valid[STAGES-1:s]);
    end

    assign in_ready_o  = w_adv[0];
    assign out_valid_o = w_valid[STAGES-1];
    assign out_tag_o   = w_tag[STAGES-1];
    // Gray->binary results sit bit-reversed in the pipe; undo that on the way out.
    assign out_data_o  = w_mode[STAGES-1] ? w_data[STAGES-1] : f_rev(w_data[STAGES-1]);

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Bench for gray_bin_conv_pipe: directed flow-control cases on an 8-bit/2-stage instance
// plus a randomized sweep over several WIDTH/STAGES configurations against a reference model.
module tb_gray_bin_conv_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic sw_rst_n = 1'b0;
    initial #23 sw_rst_n = 1'b1;

    int total = 0;
    int bad   = 0;
    int sweep_done = 0;
    localparam int NCFG = 14;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: B[i] = XOR of G[w-1:i]; G = B ^ (B>>1).
    function automatic logic [31:0] model_conv(input logic [31:0] d, input logic mode, input int w);
        logic [31:0] r;
        logic        acc;
        r   = '0;
        acc = 1'b0;
        if (mode) begin
            r = d ^ (d >> 1);
        end else begin
            for (int i = w - 1; i >= 0; i--) begin
                acc  = acc ^ d[i];
                r[i] = acc;
            end
        end
        return r & ((32'h1 << w) - 32'h1);
    endfunction

    // ---------------- main instance (8-bit, 2 stages) ----------------
    localparam int MS = 2;
    logic       in_valid, in_ready, in_mode, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [3:0] in_tag, out_tag;

    gray_bin_conv_pipe #(.WIDTH(8), .STAGES(MS), .TAG_W(4)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .in_mode_i(in_mode), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_tag_o(out_tag)
    );

    // Scoreboard for the main instance: observes handshakes #1 after each negedge.
    logic [31:0] exp_q[$];
    logic [3:0]  tag_q[$];
    int          cyc_q[$];
    int          m_cyc = 0;
    int          m_last_stall = -1;
    int          m_rcv = 0;
    logic        m_hold = 1'b0;
    logic [7:0]  m_hold_d;
    logic [3:0]  m_hold_t;

    always begin
        int c;
        @(negedge clk);
        #1;
        m_cyc++;
        if (!rst_n) begin
            exp_q.delete();
            tag_q.delete();
            cyc_q.delete();
            m_hold = 1'b0;
        end else begin
            if (m_hold) begin
                check("main hold valid", 32'(out_valid), 32'd1);
                check("main hold data", 32'(out_data), 32'(m_hold_d));
                check("main hold tag", 32'(out_tag), 32'(m_hold_t));
            end
            if (!out_ready) m_last_stall = m_cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("main spurious out", 32'(out_valid), 32'd0);
                end else begin
                    c = cyc_q.pop_front();
                    check("main data", 32'(out_data), exp_q.pop_front());
                    check("main tag", 32'(out_tag), 32'(tag_q.pop_front()));
                    if (c >= m_last_stall) check("main latency", 32'(m_cyc - c), 32'(MS));
                    else check("main latency min", 32'(m_cyc - c >= MS), 32'd1);
                    m_rcv++;
                end
            end
            m_hold   = out_valid && !out_ready;
            m_hold_d = out_data;
            m_hold_t = out_tag;
            if (in_valid && in_ready) begin
                exp_q.push_back(model_conv(32'(in_data), in_mode, 8));
                tag_q.push_back(in_tag);
                cyc_q.push_back(m_cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [7:0] d, input logic m, input logic [3:0] t);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_mode  = m;
        in_tag   = t;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 4'h0);
    endtask

    // ---------------- randomized sweep ----------------
    localparam int WS[4] = '{1, 5, 8, 13};
    localparam int NWORDS = 200;

    for (genvar gw = 0; gw < 4; gw++) begin : g_w
        localparam int W = WS[gw];
        for (genvar gs = 1; gs <= $clog2(W) + 1; gs++) begin : g_s
            logic         iv, ir, im, ov, ordy;
            logic [W-1:0] id, od;
            logic [3:0]   it, ot;
            logic [31:0]  s_exp_q[$];
            logic [3:0]   s_tag_q[$];
            int           s_cyc_q[$];
            int           sent, rcv, cyc, last_stall, c;
            logic         hold;
            logic [W-1:0] hold_d;
            logic [3:0]   hold_t;

            gray_bin_conv_pipe #(.WIDTH(W), .STAGES(gs), .TAG_W(4)) u_sw (
                .clk_i(clk), .rst_ni(sw_rst_n),
                .in_valid_i(iv), .in_ready_o(ir), .in_data_i(id),
                .in_mode_i(im), .in_tag_i(it),
                .out_valid_o(ov), .out_ready_i(ordy),
                .out_data_o(od), .out_tag_o(ot)
            );

            initial begin
                iv = 1'b0; im = 1'b0; id = '0; it = '0; ordy = 1'b0;
                sent = 0; rcv = 0; cyc = 0; last_stall = -1; hold = 1'b0;
                @(negedge clk);
                while (!sw_rst_n) @(negedge clk);
                while ((sent < NWORDS || rcv < NWORDS) && cyc < 4000) begin
                    @(negedge clk);
                    iv   = (sent < NWORDS) && ($urandom_range(0, 9) < 7);
                    id   = W'($urandom);
                    im   = 1'($urandom_range(0, 1));
                    it   = 4'($urandom);
                    ordy = ($urandom_range(0, 9) < 6);
                    #1;
                    cyc++;
                    if (hold) begin
                        check($sformatf("w%0d_s%0d hold data", W, gs), 32'(od), 32'(hold_d));
                        check($sformatf("w%0d_s%0d hold tag", W, gs), 32'(ot), 32'(hold_t));
                    end
                    if (!ordy) last_stall = cyc;
                    if (ov && ordy) begin
                        if (s_exp_q.size() == 0) begin
                            check($sformatf("w%0d_s%0d spurious", W, gs), 32'(ov), 32'd0);
                        end else begin
                            c = s_cyc_q.pop_front();
                            check($sformatf("w%0d_s%0d data", W, gs), 32'(od), s_exp_q.pop_front());
                            check($sformatf("w%0d_s%0d tag", W, gs), 32'(ot), 32'(s_tag_q.pop_front()));
                            if (c >= last_stall) check($sformatf("w%0d_s%0d latency", W, gs), 32'(cyc - c), 32'(gs));
                            else check($sformatf("w%0d_s%0d latency min", W, gs), 32'(cyc - c >= gs), 32'd1);
                            rcv++;
                        end
                    end
                    hold   = ov && !ordy;
                    hold_d = od;
                    hold_t = ot;
                    if (iv && ir) begin
                        s_exp_q.push_back(model_conv(32'(id), im, W));
                        s_tag_q.push_back(it);
                        s_cyc_q.push_back(cyc);
                        sent++;
                    end
                end
                iv = 1'b0;
                check($sformatf("w%0d_s%0d received", W, gs), 32'(rcv), 32'(NWORDS));
                sweep_done++;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int r0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst out_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst in_ready", 32'(in_ready), 32'd1);

        // T1: single word, exact latency
        drive(1'b1, 8'hC0, 1'b0, 4'd3);
        #1 check("t1 in_ready", 32'(in_ready), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 4'd0);
        #1 check("t1 not early", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("t1 valid", 32'(out_valid), 32'd1);
        check("t1 data", 32'(out_data), 32'h80);
        check("t1 tag", 32'(out_tag), 32'd3);

        // T2: mixed modes back-to-back
        drive(1'b1, 8'hFF, 1'b0, 4'd1);
        drive(1'b1, 8'hAA, 1'b1, 4'd2);
        drive(1'b0, 8'h00, 1'b0, 4'd0);
        #1;
        check("t2 first data", 32'(out_data), 32'hAA);
        check("t2 first tag", 32'(out_tag), 32'd1);
        @(negedge clk);
        #1;
        check("t2 second valid", 32'(out_valid), 32'd1);
        check("t2 second data", 32'(out_data), 32'hFF);
        check("t2 second tag", 32'(out_tag), 32'd2);
        idle_cycles(2);

        // T3: Gray-coded stream at full rate
        r0 = m_rcv;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 8'(i ^ (i >> 1)), 1'b0, 4'(i));
            #1 check("t3 in_ready", 32'(in_ready), 32'd1);
        end
        idle_cycles(4);
        #1 check("t3 count", 32'(m_rcv - r0), 32'd256);

        // T4: backpressure fills the pipe
        r0 = m_rcv;
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 1'b0, 4'hA);
        #1 check("t4 accept a", 32'(in_ready), 32'd1);
        drive(1'b1, 8'h22, 1'b1, 4'hB);
        #1 check("t4 accept b", 32'(in_ready), 32'd1);
        drive(1'b1, 8'h33, 1'b0, 4'hC);
        #1;
        check("t4 full in_ready", 32'(in_ready), 32'd0);
        check("t4 out_valid", 32'(out_valid), 32'd1);
        check("t4 out_data", 32'(out_data), 32'h1E);
        check("t4 out_tag", 32'(out_tag), 32'hA);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("t4 stall in_ready", 32'(in_ready), 32'd0);
            check("t4 stall data", 32'(out_data), 32'h1E);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 check("t4 release in_ready", 32'(in_ready), 32'd1);
        idle_cycles(5);
        #1 check("t4 drained", 32'(m_rcv - r0), 32'd3);

        // T5: async reset with words in flight
        drive(1'b1, 8'h44, 1'b0, 4'd1);
        drive(1'b1, 8'h55, 1'b1, 4'd2);
        @(posedge clk);
        #1;
        check("t5 inflight", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("t5 async valid", 32'(out_valid), 32'd0);
        check("t5 async data", 32'(out_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("t5 no stale", 32'(out_valid), 32'd0);
            check("t5 in_ready", 32'(in_ready), 32'd1);
        end

        for (int c = 0; c < 20000 && sweep_done < NCFG; c++) @(negedge clk);
        check("sweep done", 32'(sweep_done), 32'(NCFG));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
